// File: rtl/interrupt_controller_if.sv
// Interrupt controller bus: external lines, mask write port, pipeline strobes
// and the request/vector outputs. The slave side is the controller itself.
interface interrupt_controller_if #(
  parameter int unsigned NUM_IRQ = 4
);
  logic [NUM_IRQ-1:0] irq_in;
  logic               mask_we;
  logic [NUM_IRQ-1:0] mask_wdata;
  logic               int_ack;
  logic               rti_done;
  logic               interrupt;
  logic [2:0]         int_id;
  logic [31:0]        int_vector;
  logic               in_service;
  logic [NUM_IRQ-1:0] pending;

  modport master (
    output irq_in, mask_we, mask_wdata, int_ack, rti_done,
    input  interrupt, int_id, int_vector, in_service, pending
  );

  modport slave (
    input  irq_in, mask_we, mask_wdata, int_ack, rti_done,
    output interrupt, int_id, int_vector, in_service, pending
  );
endinterface

// File: rtl/interrupt_controller.sv
// Interrupt controller: latches rising edges on external lines, raises one
// request to the pipeline with the handler vector of the lowest-index unmasked
// pending source, holds it until int_ack, then blocks until rti_done.
// Optional macro IRQ_SYNC_EN adds a 2-flop synchroniser on irq_in.
module interrupt_controller #(
  parameter int unsigned NUM_IRQ       = 4,
  parameter logic [31:0] VECTOR_BASE   = 32'h0000_0000,
  parameter int unsigned VECTOR_STRIDE = 2
) (
  input logic                  clk,
  input logic                  reset,
  interrupt_controller_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t             state_q;
  logic               interrupt_q;
  logic [2:0]         int_id_q;
  logic [31:0]        int_vector_q;
  logic               in_service_q;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] mask_q;
  logic [NUM_IRQ-1:0] irq_prev_q;
  logic [NUM_IRQ-1:0] irq_s;
  logic [NUM_IRQ-1:0] edges;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] pending_clr;
  logic               any_eligible;
  logic [2:0]         winner;
  logic [31:0]        winner_vector;

`ifdef IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_q, sync2_q;

  // Two-flop synchroniser for asynchronous interrupt lines
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = bus.irq_in;
`endif

  // Edge detect, priority select and acknowledge-clear of the serviced source
  always_comb begin
    edges         = irq_s & ~irq_prev_q;
    eligible      = pending_q & ~mask_q;
    any_eligible  = |eligible;
    winner        = '0;
    pending_clr   = '0;
    for (int unsigned i = NUM_IRQ; i > 0; i--) begin
      if (eligible[i-1]) winner = 3'(i - 1);
    end
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      pending_clr[i] = (state_q == REQ) && bus.int_ack && (int_id_q == 3'(i));
    end
    // A fresh edge on the source being acknowledged survives the clear
    pending_d     = (pending_q & ~pending_clr) | edges;
    winner_vector = VECTOR_BASE + 32'(VECTOR_STRIDE) * {29'd0, winner};
  end

  // Edge history, pending events and mask register
  always_ff @(posedge clk) begin
    if (!reset) begin
      irq_prev_q <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
    end else begin
      irq_prev_q <= irq_s;
      pending_q  <= pending_d;
      if (bus.mask_we) mask_q <= bus.mask_wdata;
    end
  end

  // Request / service state machine with registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      interrupt_q  <= 1'b0;
      int_id_q     <= '0;
      int_vector_q <= VECTOR_BASE;
      in_service_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_eligible) begin
            state_q      <= REQ;
            interrupt_q  <= 1'b1;
            int_id_q     <= winner;
            int_vector_q <= winner_vector;
          end
        end
        REQ: begin
          if (bus.int_ack) begin
            state_q      <= SERVICE;
            interrupt_q  <= 1'b0;
            in_service_q <= 1'b1;
          end
        end
        SERVICE: begin
          if (bus.rti_done) begin
            state_q      <= IDLE;
            in_service_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          interrupt_q  <= 1'b0;
          in_service_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.interrupt  = interrupt_q;
  assign bus.int_id     = int_id_q;
  assign bus.int_vector = int_vector_q;
  assign bus.in_service = in_service_q;
  assign bus.pending    = pending_q;

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Source end of the pipeline's `interrupt` input to the control unit. Collects external interrupt lines and raises a single request to the pipeline.
- Supplies the handler vector and holds the request until the pipeline acknowledges entry. It then blocks further requests until the return-from-interrupt retires.
- Sits beside the fetch/decode stages. Drives `interrupt` and the vector, and receives the ack and RTI-done strobes from the control path.

Parameters:
- NUM_IRQ, 4, number of external interrupt lines (1..8).
- VECTOR_BASE, 32'h0000_0000, instruction address of the source-0 handler pointer.
- VECTOR_STRIDE, 2, address step between consecutive source vectors.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- irq_in  input  NUM_IRQ  external interrupt lines; a 0->1 transition is one event.
- mask_we  input  1  write strobe for the mask register.
- mask_wdata  input  NUM_IRQ  new mask value; bit=1 disables that source.
- int_ack  input  1  one-cycle pulse: pipeline has committed interrupt entry.
- rti_done  input  1  one-cycle pulse: return-from-interrupt retired in WB.
- interrupt  output  1  request to the control unit.
- int_id  output  3  index of the source being requested or serviced.
- int_vector  output  32  VECTOR_BASE + int_id*VECTOR_STRIDE.
- in_service  output  1  high between ack and rti_done.
- pending  output  NUM_IRQ  latched, not-yet-acknowledged events.

Behaviour:
- Reset (reset==0 at posedge): interrupt=0, int_id=0, int_vector=VECTOR_BASE, in_service=0, pending=0, mask=0 (all enabled), edge-history flops=0, state=IDLE.
  - Reset overrides everything, including mid-REQ or mid-SERVICE; any outstanding request is dropped.
- Edge detect: at each posedge, irq_prev<=irq_s, where irq_s is the (optionally synchronised) irq_in.
  - An edge on bit i (irq_s[i]=1, irq_prev[i]=0) sets pending[i].
  - A held-high line produces one event only.
- Event coalescing: a repeat edge on a source that is already pending is absorbed; there is no counter.
- Mask: when mask_we=1, mask<=mask_wdata at the posedge.
  - A masked source still latches pending but is not eligible for selection.
  - Unmasking later makes it eligible.
- Selection: the lowest-index bit of (pending & ~mask) wins. Selection is combinational; the chosen value is registered on the IDLE->REQ transition.
- State machine (registered outputs):
  - IDLE: if any eligible pending bit, go to REQ. int_id<=winner, int_vector<=VECTOR_BASE+winner*VECTOR_STRIDE (32-bit unsigned, wrap modulo 2^32), interrupt<=1.
  - REQ: interrupt stays 1; int_id and int_vector are frozen even if a higher-priority edge arrives or the mask changes. On int_ack: go to SERVICE, interrupt<=0, in_service<=1, clear pending[int_id].
  - SERVICE: no new request, no nesting. On rti_done: go to IDLE, in_service<=0. A new request can be raised at the earliest on the cycle after IDLE is re-entered.
- Latency: edge sampled at posedge P0 -> pending set after P0 -> interrupt=1 after P1 (2 cycles).
  - With ack at P2, interrupt=0 and in_service=1 after P2.
- Ignored strobes: int_ack in IDLE or SERVICE; rti_done in IDLE or REQ.
- Simultaneous events:
  - Edge on int_id in the same cycle as int_ack: the set wins, pending[int_id] stays 1 (a new event).
  - int_ack and rti_done in the same cycle in REQ: only the ack is acted on.
  - Pending set and mask write in the same cycle: both take effect.

Optional Feature:
- IRQ_SYNC_EN defined: irq_in passes through a 2-flop synchroniser (reset to 0) before edge detection. Edge-to-interrupt latency becomes 4 cycles.
- IRQ_SYNC_EN undefined: irq_s=irq_in directly, latency 2 cycles; inputs must already be synchronous to clk.

Test Plan:
- Reset mid-REQ: raise irq_in[1], then reset=0 for one cycle -> interrupt=0, pending=0, int_vector=32'h0; no request follows until a new edge.
- Single event: irq_in[2] 0->1 and held high, VECTOR_BASE=32'h100 -> interrupt=1 two cycles later, int_id=2, int_vector=32'h104.
  - int_ack -> interrupt=0, in_service=1, pending[2]=0; the held line raises nothing further.
- Priority and freeze: edges on irq 3 and 1 together -> int_id=1. An irq0 edge during REQ leaves int_id=1.
  - After ack and rti_done, next request int_id=0, then int_id=3.
- No nesting: in SERVICE, pulse irq_in[0] -> interrupt stays 0, pending[0]=1. rti_done -> interrupt=1 on the following cycle with int_id=0.
- Mask: mask=4'b0001, irq0 edge -> pending[0]=1, interrupt stays 0 for 10 cycles. Write mask=0 -> interrupt=1 within 2 cycles.
- Coalesce and stray strobes: 3 irq1 edges before ack -> one request only. int_ack in IDLE and rti_done in REQ -> no state change.
